rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WidthOfInputs, default 32: data bits per input channel, minimum 1.
REQ-002 SHALL have parameter NumberOfInputs, default 4: input channel count, minimum 2.
REQ-003 SHALL have parameter PacketLock, default 0: 0 re-arbitrates every beat; 1 holds the grant until the granted channel's last beat.
REQ-004 SHALL have Clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have Reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ConcatanatedInputs, input, NumberOfInputs*WidthOfInputs: channel i occupies bits [i*W +: W].
REQ-007 SHALL have In_Valid, input, NumberOfInputs: per-channel data valid.
REQ-008 SHALL have In_Last, input, NumberOfInputs: per-channel last-beat flag, meaningful only when PacketLock=1.
REQ-009 SHALL have In_Ready, output, NumberOfInputs: per-channel accept, one-hot or zero.
REQ-010 SHALL have Out, output, WidthOfInputs: registered selected data.
REQ-011 SHALL have Out_Valid, output, 1: Out holds a beat.
REQ-012 SHALL have Out_Last, output, 1: registered In_Last of the accepted beat.
REQ-013 SHALL have Out_Select, output, SelW = clog2(NumberOfInputs): index of the channel that sourced Out.
REQ-014 SHALL have Out_Ready, input, 1: downstream accept.

Function
REQ-015 A beat transfers on an input when In_Valid[i] and In_Ready[i] are both high at a rising Clock; it transfers on the output when Out_Valid and Out_Ready are both high.
REQ-016 Output register "open" = !Out_Valid || Out_Ready; In_Ready SHALL be all-zero while not open.
REQ-017 While open, In_Ready SHALL be one-hot on the granted channel; it SHALL be zero when no In_Valid is high.
REQ-018 Round-robin: search starts at (LastGrant+1) mod NumberOfInputs and picks the first valid channel; LastGrant updates only on an input transfer.
REQ-019 Latency: an accepted beat SHALL appear on Out/Out_Last/Out_Select the next cycle with Out_Valid=1; no combinational path from ConcatanatedInputs to Out.
REQ-020 Simultaneous output transfer and input transfer SHALL load the new beat, keeping Out_Valid=1 (full throughput, one beat/cycle).
REQ-021 Output transfer with no input transfer SHALL clear Out_Valid; Out holds its last value.
REQ-022 Out, Out_Last and Out_Select SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-023 PacketLock=1 state machine: ARB -> LOCK on an accepted beat with In_Last=0, locking that channel; LOCK -> ARB on an accepted locked-channel beat with In_Last=1; an In_Last=1 beat accepted in ARB stays in ARB.
REQ-024 In LOCK, only the locked channel SHALL be granted, even if it deasserts In_Valid; other channels wait.
REQ-025 PacketLock=0: state stays ARB; In_Last is passed through to Out_Last only.
REQ-026 Wrap-around: with LastGrant=NumberOfInputs-1, the search SHALL start at channel 0.
REQ-027 NumberOfInputs not a power of two: unused Select codes SHALL never be produced.

Reset
REQ-028 Reset_n low SHALL asynchronously force Out_Valid=0, Out=0, Out_Last=0, Out_Select=0, state=ARB, LastGrant=NumberOfInputs-1, so channel 0 has first priority.
REQ-029 In_Ready SHALL be 0 while Reset_n is low; reset mid-packet discards the lock and any held beat.
REQ-030 Deassertion SHALL take effect at the first rising Clock after Reset_n rises; no transfers occur before that edge.

Structure
REQ-031 A shared package SHALL hold the state encoding (ARB, LOCK) and the clog2 helper function.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_grant (request vector, pointer -> one-hot grant and index); data selection SHALL reuse the existing Muxn shift mux driven by the grant index.

Verification
REQ-033 N=4, W=8: all four valid with data 0x10..0x13, Out_Ready=1 -> Out_Select 0,1,2,3,0 on consecutive cycles, Out matches, no bubbles.
REQ-034 Out_Ready=0 for 3 cycles with Out_Valid=1 -> Out stable, In_Ready=0000; Out_Ready=1 -> next beat loads the same cycle.
REQ-035 PacketLock=1: ch1 sends 3 beats (In_Last on beat 3) while ch2 is valid; a ch1 valid gap mid-packet -> ch2 waits, never granted until after ch1's beat 3.
REQ-036 N=3: only ch2 valid, then only ch0 valid -> grants 2 then 0 (wrap); Out_Select never equals 3.
REQ-037 Reset_n pulsed low mid-packet with Out_Valid=1 -> immediate Out_Valid=0, In_Ready=0; after release, ch0 has first priority.
REQ-038 Random valid/ready stress against a scoreboard -> no beat lost, duplicated or reordered per channel; fairness gap per channel is at most N-1 grants.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux: arbitration state
// encoding and the select-width helper.
package rr_arb_mux_pkg;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  // Bits needed to index n channels; never less than 1 so selects stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/muxn.sv
// Shift-based N:1 data selector over a concatenated input bus; channel i
// occupies bits [i*Width +: Width].
module Muxn #(
  parameter int unsigned Width  = 32,
  parameter int unsigned Inputs = 4,
  parameter int unsigned SelW   = 2
) (
  input  logic [Inputs*Width-1:0] data_in,
  input  logic [SelW-1:0]         sel,
  output logic [Width-1:0]        data_out
);

  assign data_out = Width'(data_in >> (sel * Width));

endmodule

// File: rtl/rr_grant.sv
// Round-robin grant: searches upward from ptr+1 (mod N) and returns the first
// requesting channel as a one-hot grant plus its index.
module rr_grant #(
  parameter int unsigned N    = 4,
  parameter int unsigned SelW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SelW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SelW-1:0] idx,
  output logic            any
);

  int unsigned c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = SelW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrating mux with a single registered output stage and
// optional packet locking that holds a grant until the channel's last beat.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned WidthOfInputs  = 32,
  parameter int unsigned NumberOfInputs = 4,
  parameter bit          PacketLock     = 1'b0
) (
  input  logic                                    Clock,
  input  logic                                    Reset_n,
  input  logic [NumberOfInputs*WidthOfInputs-1:0] ConcatanatedInputs,
  input  logic [NumberOfInputs-1:0]               In_Valid,
  input  logic [NumberOfInputs-1:0]               In_Last,
  output logic [NumberOfInputs-1:0]               In_Ready,
  output logic [WidthOfInputs-1:0]                Out,
  output logic                                    Out_Valid,
  output logic                                    Out_Last,
  output logic [clog2(NumberOfInputs)-1:0]        Out_Select,
  input  logic                                    Out_Ready
);

  localparam int unsigned N    = NumberOfInputs;
  localparam int unsigned W    = WidthOfInputs;
  localparam int unsigned SelW = clog2(NumberOfInputs);

  logic            out_valid_q;
  logic [W-1:0]    out_q;
  logic            out_last_q;
  logic [SelW-1:0] out_sel_q;
  logic [SelW-1:0] last_grant_q;
  logic [0:0]      state_q, state_d;

  logic            open;
  logic [N-1:0]    lock_mask;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [SelW-1:0] grant_idx;
  logic            grant_any;
  logic            xfer_in;
  logic            grant_last;
  logic [W-1:0]    mux_data;

  assign open = !out_valid_q || Out_Ready;

  // While locked, last_grant_q is the locked channel; everyone else is masked.
  always_comb begin
    lock_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lock_mask[i] = (state_q == ARB) || (last_grant_q == SelW'(i));
    end
  end

  assign req = In_Valid & lock_mask;

  rr_grant #(
    .N    (N),
    .SelW (SelW)
  ) u_grant (
    .req   (req),
    .ptr   (last_grant_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  Muxn #(
    .Width  (W),
    .Inputs (N),
    .SelW   (SelW)
  ) u_mux (
    .data_in  (ConcatanatedInputs),
    .sel      (grant_idx),
    .data_out (mux_data)
  );

  assign In_Ready   = (open && Reset_n) ? grant : '0;
  assign xfer_in    = open && Reset_n && grant_any;
  assign grant_last = In_Last[grant_idx];

  always_comb begin
    state_d = state_q;
    if (PacketLock && xfer_in) begin
      case (state_q)
        ARB:     if (!grant_last) state_d = LOCK;
        LOCK:    if (grant_last) state_d = ARB;
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_last_q   <= 1'b0;
      out_sel_q    <= '0;
      last_grant_q <= SelW'(N - 1);
      state_q      <= ARB;
    end else begin
      state_q <= state_d;
      if (xfer_in) begin
        out_valid_q  <= 1'b1;
        out_q        <= mux_data;
        out_last_q   <= grant_last;
        out_sel_q    <= grant_idx;
        last_grant_q <= grant_idx;
      end else if (Out_Ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign Out        = out_q;
  assign Out_Valid  = out_valid_q;
  assign Out_Last   = out_last_q;
  assign Out_Select = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: vector table, hand sequences for locking
// and reset, and randomised stress against a reference model and scoreboard.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] din4;
  logic [3:0]  v4, l4;
  logic        ordy4;
  logic [3:0]  irdy0, irdy1;
  logic [7:0]  out0, out1;
  logic        ov0, ov1, ol0, ol1;
  logic [1:0]  os0, os1;

  logic [23:0] din3;
  logic [2:0]  v3, l3, irdy3;
  logic [7:0]  out3;
  logic        ov3, ol3, ordy3;
  logic [1:0]  os3;

  bit use_lock;

  logic [3:0] irdy;
  logic [7:0] dout;
  logic       ov, ol;
  logic [1:0] os;
  assign irdy = use_lock ? irdy1 : irdy0;
  assign dout = use_lock ? out1 : out0;
  assign ov   = use_lock ? ov1 : ov0;
  assign ol   = use_lock ? ol1 : ol0;
  assign os   = use_lock ? os1 : os0;

  rr_arb_mux #(.WidthOfInputs(8), .NumberOfInputs(4), .PacketLock(1'b0)) u_dut0 (
    .Clock(clk), .Reset_n(rst_n), .ConcatanatedInputs(din4), .In_Valid(v4), .In_Last(l4),
    .In_Ready(irdy0), .Out(out0), .Out_Valid(ov0), .Out_Last(ol0), .Out_Select(os0),
    .Out_Ready(ordy4)
  );

  rr_arb_mux #(.WidthOfInputs(8), .NumberOfInputs(4), .PacketLock(1'b1)) u_dut1 (
    .Clock(clk), .Reset_n(rst_n), .ConcatanatedInputs(din4), .In_Valid(v4), .In_Last(l4),
    .In_Ready(irdy1), .Out(out1), .Out_Valid(ov1), .Out_Last(ol1), .Out_Select(os1),
    .Out_Ready(ordy4)
  );

  rr_arb_mux #(.WidthOfInputs(8), .NumberOfInputs(3), .PacketLock(1'b0)) u_dut3 (
    .Clock(clk), .Reset_n(rst_n), .ConcatanatedInputs(din3), .In_Valid(v3), .In_Last(l3),
    .In_Ready(irdy3), .Out(out3), .Out_Valid(ov3), .Out_Last(ol3), .Out_Select(os3),
    .Out_Ready(ordy3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] sel;
  } beat_t;

  beat_t sbq[$];
  int    m_lg;
  bit    m_lock;
  int    wait_cnt[4];

  task automatic model_reset();
    sbq.delete();
    m_lg   = 3;
    m_lock = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v4 = '0; l4 = '0; ordy4 = 1'b0; din4 = '0;
    v3 = '0; l3 = '0; ordy3 = 1'b0; din3 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle on the 4-channel DUT under test, checked against the model.
  task automatic step(output int g);
    bit    exp_ov, open;
    beat_t b, nb;
    int    c;
    #1;
    exp_ov = (sbq.size() != 0);
    chk("out_valid", {31'd0, ov}, {31'd0, exp_ov});
    open = !exp_ov || ordy4;
    g = -1;
    if (open) begin
      if (m_lock) begin
        if (v4[m_lg]) g = m_lg;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_lg + k) % 4;
          if (g < 0 && v4[c]) g = c;
        end
      end
    end
    chk("in_ready", {28'd0, irdy}, (g >= 0) ? (32'd1 << g) : 32'd0);
    if (exp_ov && ordy4) begin
      b = sbq.pop_front();
      chk("out_data", {24'd0, dout}, {24'd0, b.data});
      chk("out_last", {31'd0, ol}, {31'd0, b.last});
      chk("out_sel", {30'd0, os}, {30'd0, b.sel});
    end
    if (g >= 0) begin
      nb.data = din4[g*8 +: 8];
      nb.last = l4[g];
      nb.sel  = 2'(g);
      sbq.push_back(nb);
      m_lg = g;
      if (use_lock) begin
        if (!m_lock && !l4[g]) m_lock = 1'b1;
        else if (m_lock && l4[g]) m_lock = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (i == g) begin
          if (!use_lock) chk("fairness_gap", {31'd0, wait_cnt[i] <= 3}, 32'd1);
          wait_cnt[i] = 0;
        end else if (v4[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) if (!v4[i]) wait_cnt[i] = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sources hold each beat until accepted; data tags channel and sequence.
  task automatic rand_run(input int cycles, input int last_pct);
    bit have[4];
    int seq[4];
    int g;
    for (int i = 0; i < 4; i++) begin
      have[i] = 1'b0;
      seq[i]  = 0;
    end
    for (int n = 0; n < cycles; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!have[i] && $urandom_range(0, 99) < 60) begin
          have[i] = 1'b1;
          din4[i*8 +: 8] = {i[1:0], seq[i][5:0]};
          l4[i] = ($urandom_range(0, 99) < last_pct);
        end
        v4[i] = have[i];
      end
      ordy4 = ($urandom_range(0, 99) < 70);
      step(g);
      if (g >= 0) begin
        have[g] = 1'b0;
        seq[g]++;
      end
    end
    v4 = '0;
    ordy4 = 1'b1;
    repeat (3) step(g);
  endtask

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic [3:0] e_irdy;
    logic       e_ov;
    logic [1:0] e_sel;
    logic [7:0] e_out;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n = 1'b0;
    v4 = '0; l4 = '0; ordy4 = 1'b0; din4 = '0;
    v3 = '0; l3 = '0; ordy3 = 1'b0; din3 = '0;
    use_lock = 1'b0;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h10};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 8'h11};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h12};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h13};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h10};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h11};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};
    tbl[11] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd1, 8'h11};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
    tbl[13] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h12};
    tbl[14] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h13};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h10};

    // Vector table on the re-arbitrating DUT.
    do_reset();
    din4 = 32'h1312_1110;
    for (int i = 0; i < 17; i++) begin
      v4 = tbl[i].v;
      ordy4 = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), {28'd0, irdy}, {28'd0, tbl[i].e_irdy});
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, ov}, {31'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_out_sel", i), {30'd0, os}, {30'd0, tbl[i].e_sel});
      chk($sformatf("tbl%0d_out", i), {24'd0, dout}, {24'd0, tbl[i].e_out});
      @(posedge clk);
      @(negedge clk);
    end

    // Packet lock: ch1 packet with a valid gap while ch2 waits.
    use_lock = 1'b1;
    do_reset();
    ordy4 = 1'b1;
    v4 = 4'b0110; l4 = 4'b0000; din4 = 32'h00B1_A100;
    step(g);
    din4 = 32'h00B1_A200;
    step(g);
    v4 = 4'b0100;
    #1;
    chk("lock_gap_in_ready", {28'd0, irdy}, 32'd0);
    step(g);
    v4 = 4'b0110; l4 = 4'b0010; din4 = 32'h00B1_A300;
    step(g);
    v4 = 4'b0100; l4 = 4'b0000;
    #1;
    chk("lock_release_ch2", {28'd0, irdy}, 32'h4);
    step(g);
    v4 = 4'b0000;
    repeat (2) step(g);

    // Reset mid-packet with a held beat.
    do_reset();
    v4 = 4'b0010; l4 = 4'b0000; din4 = 32'h0000_C100; ordy4 = 1'b0;
    step(g);
    v4 = 4'b0110;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, ov}, 32'd0);
    chk("rst_in_ready", {28'd0, irdy}, 32'd0);
    chk("rst_out", {24'd0, dout}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    v4 = 4'b1111; l4 = 4'b1111; din4 = 32'h1312_1110; ordy4 = 1'b1;
    #1;
    chk("post_rst_priority", {28'd0, irdy}, 32'h1);
    step(g);
    v4 = 4'b0000;
    repeat (2) step(g);

    // Random stress, both modes.
    use_lock = 1'b0;
    do_reset();
    rand_run(2000, 30);
    use_lock = 1'b1;
    do_reset();
    rand_run(2000, 30);

    // Three channels: wrap-around and select range.
    do_reset();
    ordy3 = 1'b1;
    din3 = 24'h22_2120;
    v3 = 3'b100;
    #1;
    chk("n3_grant_ch2", {29'd0, irdy3}, 32'h4);
    chk("n3_idle_valid", {31'd0, ov3}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b001;
    #1;
    chk("n3_wrap_ch0", {29'd0, irdy3}, 32'h1);
    chk("n3_sel2", {30'd0, os3}, 32'd2);
    chk("n3_out2", {24'd0, out3}, 32'h22);
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b000;
    #1;
    chk("n3_valid", {31'd0, ov3}, 32'd1);
    chk("n3_sel0", {30'd0, os3}, 32'd0);
    chk("n3_out0", {24'd0, out3}, 32'h20);
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 200; n++) begin
      v3 = 3'($urandom_range(0, 7));
      ordy3 = ($urandom_range(0, 99) < 70);
      #1;
      chk("n3_sel_range", {31'd0, os3 < 2'd3}, 32'd1);
      chk("n3_ready_onehot0", {31'd0, $onehot0(irdy3)}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
